// File: rtl/mo_tape_recorder.sv
// Cassette save path: samples tape_out while the motor runs, packs 1 bit per sample
// into RAM and serves it as an 8-bit mono WAV upload. Optional TAPE_REC_MONITOR_EN adds audio_mon.
module mo_tape_recorder #(
   parameter int CLK_HZ    = 50000000,
   parameter int SAMPLE_HZ = 44100,
   parameter int ADDR_W    = 16
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              rec_ena,
   input  logic              motor,
   input  logic              tape_out,
   input  logic              ioctl_upload,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              recording,
   output logic              overflow,
   output logic [ADDR_W+3:0] rec_samples
`ifdef TAPE_REC_MONITOR_EN
   ,
   output logic signed [15:0] audio_mon
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_REC, S_FLUSH, S_FULL, S_UPLOAD
   } state_t;

   localparam logic [32:0]       C_CLK  = 33'(CLK_HZ);
   localparam logic [32:0]       C_SMP  = 33'(SAMPLE_HZ);
   localparam logic [ADDR_W+3:0] C_BYTE = (ADDR_W+4)'(8);

   state_t              r_state, w_state_nxt;
   state_t              r_ret, w_ret_nxt;
   logic [31:0]         r_acc;
   logic                r_rec_d;
   logic [7:0]          r_shift;
   logic [2:0]          r_bitcnt;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W+3:0]   r_samples;
   logic                r_ovf;
   logic [24:0]         r_rd_addr;
   logic                r_rd_pend;
   logic [7:0]          r_din;
   logic [7:0]          r_ram [0:(1<<ADDR_W)-1];

   logic [32:0] w_sum;
   logic        w_tick;
   logic [31:0] w_acc_nxt;
   logic        w_rise;
   logic        w_clear;
   logic        w_cap;
   logic        w_wr;
   logic        w_ovf_set;
   logic [7:0]  w_cap_byte;
   logic [7:0]  w_pad;
   logic [7:0]  w_wr_data;
   logic        w_wrap;

   assign w_sum     = {1'b0, r_acc} + C_SMP;
   assign w_tick    = (w_sum >= C_CLK);
   assign w_acc_nxt = w_tick ? 32'(w_sum - C_CLK) : w_sum[31:0];
   assign w_rise    = rec_ena & ~r_rec_d;
   assign w_wrap    = (r_wr_ptr == {ADDR_W{1'b1}});

   // Samples are LSB first; a partial byte is right-aligned and padded with its last sample
   assign w_cap_byte = {tape_out, r_shift[7:1]};
   assign w_pad = (r_shift >> (4'd8 - {1'b0, r_bitcnt}))
                | ({8{r_shift[7]}} << r_bitcnt);

   always_comb begin
      w_state_nxt = r_state;
      w_ret_nxt   = r_ret;
      w_clear     = 1'b0;
      w_cap       = 1'b0;
      w_wr        = 1'b0;
      w_ovf_set   = 1'b0;
      w_wr_data   = w_cap_byte;
      case (r_state)
         S_IDLE: begin
            if (ioctl_upload) begin
               w_state_nxt = S_UPLOAD;
            end else if (w_rise) begin
               w_clear     = 1'b1;
               w_state_nxt = S_ARMED;
            end
         end
         S_ARMED: begin
            if (ioctl_upload)  w_state_nxt = S_UPLOAD;
            else if (!rec_ena) w_state_nxt = S_IDLE;
            else if (motor)    w_state_nxt = S_REC;
         end
         S_REC: begin
            w_cap = w_tick;
            w_wr  = w_tick && (r_bitcnt == 3'd7);
            if (w_wr && w_wrap) begin
               w_ovf_set   = 1'b1;
               w_state_nxt = S_FULL;
            end else if (ioctl_upload) begin
               w_state_nxt = S_FLUSH;
               w_ret_nxt   = S_UPLOAD;
            end else if (!rec_ena) begin
               w_state_nxt = S_FLUSH;
               w_ret_nxt   = S_IDLE;
            end else if (!motor) begin
               w_state_nxt = S_FLUSH;
               w_ret_nxt   = S_ARMED;
            end
         end
         S_FLUSH: begin
            w_wr_data = w_pad;
            if (r_bitcnt != 3'd0) begin
               w_wr      = 1'b1;
               w_ovf_set = w_wrap;
            end
            if (w_ovf_set && (r_ret != S_UPLOAD)) w_state_nxt = S_FULL;
            else                                  w_state_nxt = r_ret;
         end
         S_FULL: begin
            if (ioctl_upload)  w_state_nxt = S_UPLOAD;
            else if (!rec_ena) w_state_nxt = S_IDLE;
         end
         S_UPLOAD: begin
            if (!ioctl_upload) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ret   <= S_IDLE;
         r_acc   <= '0;
         r_rec_d <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ret   <= w_ret_nxt;
         r_acc   <= w_acc_nxt;
         r_rec_d <= rec_ena;
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_shift   <= '0;
         r_bitcnt  <= '0;
         r_wr_ptr  <= '0;
         r_samples <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_clear) begin
            r_bitcnt  <= '0;
            r_wr_ptr  <= '0;
            r_samples <= '0;
            r_ovf     <= 1'b0;
         end
         if (w_cap) begin
            r_shift  <= w_cap_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
         end
         if (r_state == S_FLUSH) r_bitcnt <= '0;
         if (w_wr) begin
            r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
            r_samples <= r_samples + C_BYTE;
         end
         if (w_ovf_set) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (w_wr) r_ram[r_wr_ptr] <= w_wr_data;
   end

   logic [31:0]       w_n32;
   logic [24:0]       w_off;
   logic [ADDR_W-1:0] w_idx;
   logic [7:0]        w_ram_q;
   logic              w_in_data;
   logic [31:0]       w_word;
   logic [7:0]        w_hdr;
   logic [7:0]        w_rd_byte;

   assign w_n32     = 32'(r_samples);
   assign w_off     = r_rd_addr - 25'd44;
   assign w_idx     = w_off[ADDR_W+2:3];
   assign w_ram_q   = r_ram[w_idx];
   assign w_in_data = (32'(w_off) < w_n32);

   // Header as little-endian 32-bit words, byte picked by the low address bits
   always_comb begin
      w_word = 32'h0;
      case (r_rd_addr[5:2])
         4'd0:    w_word = 32'h46464952;
         4'd1:    w_word = 32'd36 + w_n32;
         4'd2:    w_word = 32'h45564157;
         4'd3:    w_word = 32'h20746d66;
         4'd4:    w_word = 32'd16;
         4'd5:    w_word = 32'h00010001;
         4'd6:    w_word = 32'(SAMPLE_HZ);
         4'd7:    w_word = 32'(SAMPLE_HZ);
         4'd8:    w_word = 32'h00080001;
         4'd9:    w_word = 32'h61746164;
         4'd10:   w_word = w_n32;
         default: w_word = 32'h0;
      endcase
      case (r_rd_addr[1:0])
         2'd0:    w_hdr = w_word[7:0];
         2'd1:    w_hdr = w_word[15:8];
         2'd2:    w_hdr = w_word[23:16];
         default: w_hdr = w_word[31:24];
      endcase
   end

   always_comb begin
      w_rd_byte = 8'h80;
      if (r_rd_addr < 25'd44)
         w_rd_byte = w_hdr;
      else if (w_in_data)
         w_rd_byte = w_ram_q[w_off[2:0]] ? 8'hC0 : 8'h40;
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_rd_addr <= '0;
         r_rd_pend <= 1'b0;
         r_din     <= '0;
      end else begin
         r_rd_pend <= ioctl_rd;
         if (ioctl_rd)  r_rd_addr <= ioctl_addr;
         if (r_rd_pend) r_din     <= w_rd_byte;
      end
   end

`ifdef TAPE_REC_MONITOR_EN
   logic signed [15:0] r_mon;
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset)                 r_mon <= '0;
      else if (r_state == S_REC) r_mon <= tape_out ? 16'sh1000 : -16'sh1000;
      else                       r_mon <= '0;
   end
   assign audio_mon = r_mon;
`endif

   assign ioctl_din   = r_din;
   assign recording   = (r_state == S_REC);
   assign overflow    = r_ovf;
   assign rec_samples = r_samples;

endmodule

// File: doc/mo_tape_recorder.md
Name: mo_tape_recorder

Overview:
- Cassette save path, core to HPS direction: samples the MO5/MO6 cassette output bit while the motor runs.
- Packs samples 1 bit each into an internal block RAM.
- Serves the recording to the HPS as an 8-bit mono PCM WAV file through the ioctl upload handshake.
- Sits inside mo_core beside the WAV tape loader; the tape loader is the download/read side, this block is the upload/write side.

Parameters:
- CLK_HZ, 50000000, sysclk frequency in Hz, used for sample-rate generation.
- SAMPLE_HZ, 44100, WAV sample rate in Hz; also written into the WAV header.
- ADDR_W, 16, byte-address width of the sample RAM; capacity is 2^ADDR_W bytes = 2^(ADDR_W+3) samples.

Ports:
- sysclk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rec_ena  in  1  recording armed (OSD); level.
- motor  in  1  cassette motor on from the PIA; level.
- tape_out  in  1  cassette output bit from the core.
- ioctl_upload  in  1  HPS upload in progress.
- ioctl_rd  in  1  one-cycle read strobe for the byte at ioctl_addr.
- ioctl_addr  in  25  byte offset in the WAV file.
- ioctl_din  out  8  requested WAV byte.
- recording  out  1  high while in state REC.
- overflow  out  1  sticky; set when the RAM fills.
- rec_samples  out  ADDR_W+4  number of samples recorded, always a multiple of 8.

Behaviour:
- Reset values: ioctl_din=0, recording=0, overflow=0, rec_samples=0, state=IDLE, phase accumulator=0.
- Sample tick, 32-bit phase accumulator:
  - Each cycle compute acc+SAMPLE_HZ.
  - If the sum is >= CLK_HZ: tick=1 and acc=sum-CLK_HZ. Otherwise acc=sum.
  - The accumulator runs in every state.
- Packing:
  - Each tick in REC shifts tape_out into an 8-bit shift register, LSB first, and advances a 3-bit bit counter.
  - On the 8th bit the byte is written to RAM[wr_ptr] on the same cycle, wr_ptr increments, and rec_samples += 8.
- States:
  - IDLE: no capture; RAM and rec_samples retained. A rising edge of rec_ena clears wr_ptr, rec_samples, overflow and the bit counter, then goes to ARMED.
  - ARMED: waits. motor=1 -> REC. rec_ena=0 -> IDLE.
  - REC: captures on ticks.
    - motor=0 -> FLUSH, return to ARMED.
    - rec_ena=0 -> FLUSH, return to IDLE.
    - wr_ptr wraps to 0 after a write -> overflow=1 -> FULL.
  - FLUSH: one cycle. If the bit counter is nonzero, pad the remaining bits with the last sampled bit, write the byte, and rec_samples += 8. Then go to the return state.
  - FULL: no capture. rec_ena=0 -> IDLE.
  - UPLOAD: entered from any state while ioctl_upload=1.
    - Entry from REC passes through FLUSH first.
    - Capture is frozen during UPLOAD.
    - ioctl_upload=0 -> IDLE.
- Simultaneous events:
  - Tick plus motor falling in the same cycle: the tick sample is captured first, then FLUSH.
  - rec_ena rising while ioctl_upload=1 is ignored.
- Read path:
  - On ioctl_rd, latch ioctl_addr. The next cycle reads RAM. ioctl_din is valid 2 cycles after ioctl_rd and holds until the next ioctl_rd.
  - N = rec_samples.
  - Addr 0..43 returns the canonical 44-byte PCM header, multi-byte fields little-endian:
    - "RIFF", then 36+N (32-bit).
    - "WAVE", "fmt ", then 16 (32-bit).
    - Format 1 (16-bit), channels 1 (16-bit).
    - SAMPLE_HZ (32-bit) twice: sample rate and byte rate.
    - Block align 1 (16-bit), bits per sample 8 (16-bit).
    - "data", then N (32-bit).
  - Addr 44..43+N: i=addr-44; returns 8'hC0 if RAM[i>>3] bit i[2:0] is 1, else 8'h40.
  - Addr >= 44+N returns 8'h80 (silence).
- Reset mid-operation: all state and outputs go to reset values. RAM contents are undefined, but rec_samples=0 makes them unreachable.

Optional Feature:
- Macro TAPE_REC_MONITOR_EN.
- Defined: adds output port audio_mon [15:0] signed, registered, reset 0.
  - In REC: audio_mon = 16'sh1000 when tape_out=1, else -16'sh1000.
  - All other states: 0.
- Undefined: the port and its logic are absent.

Test Plan:
- Bench setup: CLK_HZ=441000, SAMPLE_HZ=44100 (one tick per 10 clocks), ADDR_W=4.
- Tick rate: rec_ena=1, motor=1, run 1000 cycles -> exactly 100 ticks captured, recording=1.
- Capture and header: drive tape_out pattern 1,0,1,1,0,0,0,0 for 8 ticks, then motor=0 -> rec_samples=8. Upload reads:
  - addr 44 -> 8'hC0, addr 45 -> 8'h40, addr 47 -> 8'hC0, addr 52 -> 8'h80.
  - addr 40..43 -> 08 00 00 00; addr 4 -> 8'h2C.
- Flush padding: record 3 ticks of 1, then motor=0 -> rec_samples=8, and upload bytes 44..51 are all 8'hC0.
- Overflow: motor held on for 128+ ticks -> after the 128th sample overflow=1, state FULL, rec_samples=128; further ticks leave the count unchanged.
- Read latency: ioctl_rd pulse at cycle t with addr 0 -> ioctl_din=8'h52 at t+2 and held until the next ioctl_rd.
- Async reset during REC: reset asserted asynchronously mid-REC -> recording, overflow, rec_samples all 0 immediately; after release, an upload read at addr 44 returns 8'h80.
